// File: rtl/comparator_seq.sv
// Purpose : multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, unsigned or two's complement.
// Latency : start edge to done = k+1 edges on early exit at slice k, N = WIDTH/DIGIT edges otherwise.
// Backpressure: none; start is accepted only in IDLE and ignored (not queued) while busy or done.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   start, signed_mode     request (sampled in IDLE) and operand format, latched with start
//   a, b                   WIDTH-bit operands, latched with start
//   busy                   high while comparing
//   done                   one-cycle pulse; smaller/equal/greater valid and held until next done
module comparator_seq #(
  parameter int WIDTH      = 8,  // >= 2
  parameter int DIGIT      = 1,  // must divide WIDTH
  parameter int EARLY_EXIT = 1   // 1: stop at first differing slice
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             smaller,
  output logic             equal,
  output logic             greater
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             dec_q;  // a differing slice has been seen
  logic             gt_q;   // recorded decision: A > B

  logic [DIGIT-1:0] sa, sb;
  logic             dec_d, gt_d, last_slice, finish;

  // Operands shift left after each slice, so the slice under test is always the top DIGIT bits.
  always_comb begin
    sa         = a_q[WIDTH-1 -: DIGIT];
    sb         = b_q[WIDTH-1 -: DIGIT];
    dec_d      = dec_q | (sa != sb);
    // Once a decision is recorded, later slices cannot override it.
    gt_d       = dec_q ? gt_q : (sa > sb);
    last_slice = (idx_q == IDX_W'(N - 1));
    finish     = last_slice | ((EARLY_EXIT != 0) & dec_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      gt_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      smaller <= 1'b0;
      equal   <= 1'b0;
      greater <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CMP;
            busy    <= 1'b1;
            // Flipping the sign bit maps two's complement onto offset binary,
            // so the rest of the compare is purely unsigned.
            a_q     <= signed_mode ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
            b_q     <= signed_mode ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
          end
        end
        CMP: begin
          if (finish) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            smaller <= dec_d & ~gt_d;
            greater <= dec_d & gt_d;
            equal   <= ~dec_d;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            a_q   <= a_q << DIGIT;
            b_q   <= b_q << DIGIT;
            dec_q <= dec_d;
            gt_q  <= gt_d;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Scoreboard bench for comparator_seq: three instances (bit-serial early-exit,
// bit-serial fixed latency, 4-bit digits early-exit). The driver pushes the
// expected result and done edge; a negedge monitor pops and compares on done.
module tb_comparator_seq;

  localparam logic [2:0] LT = 3'b100;  // {smaller, equal, greater}
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_r, sm_r;
  logic [7:0] a_r [3];
  logic [7:0] b_r [3];
  logic [2:0] busy_w, done_w, sm_w, eq_w, gt_w;

  int   cyc;
  int   checks;
  int   errors;
  int   bcount;
  exp_t q0[$], q1[$], q2[$];

  comparator_seq #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .signed_mode(sm_r[0]),
    .a(a_r[0]), .b(b_r[0]), .busy(busy_w[0]), .done(done_w[0]),
    .smaller(sm_w[0]), .equal(eq_w[0]), .greater(gt_w[0]));

  comparator_seq #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .signed_mode(sm_r[1]),
    .a(a_r[1]), .b(b_r[1]), .busy(busy_w[1]), .done(done_w[1]),
    .smaller(sm_w[1]), .equal(eq_w[1]), .greater(gt_w[1]));

  comparator_seq #(.WIDTH(8), .DIGIT(4), .EARLY_EXIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .signed_mode(sm_r[2]),
    .a(a_r[2]), .b(b_r[2]), .busy(busy_w[2]), .done(done_w[2]),
    .smaller(sm_w[2]), .equal(eq_w[2]), .greater(gt_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) if (busy_w[1]) bcount = bcount + 1;

  task automatic pop_chk(input int d, input logic [2:0] got);
    exp_t e;
    bit   empty;
    empty = 1'b0;
    case (d)
      0: begin empty = (q0.size() == 0); if (!empty) e = q0.pop_front(); end
      1: begin empty = (q1.size() == 0); if (!empty) e = q1.pop_front(); end
      default: begin empty = (q2.size() == 0); if (!empty) e = q2.pop_front(); end
    endcase
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL spurious_done dut%0d at edge %0d got %b required no done", d, cyc, got);
    end else begin
      if (got !== e.res) begin
        errors++;
        $display("FAIL result dut%0d got %b required %b", d, got, e.res);
      end
      checks++;
      if (cyc != e.cyc) begin
        errors++;
        $display("FAIL latency dut%0d done at edge %0d required edge %0d", d, cyc, e.cyc);
      end
    end
  endtask

  // Monitor: decoupled from the driver, reacts only to done pulses.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (done_w[d] === 1'b1) pop_chk(d, {sm_w[d], eq_w[d], gt_w[d]});
  end

  // Called at a negedge; returns at the negedge of the first IDLE cycle after DONE.
  task automatic issue(input int d, input bit sm, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] res, input int lat, input bit hold, input bit tog);
    exp_t e;
    start_r[d] = 1'b1;
    sm_r[d]    = sm;
    a_r[d]     = av;
    b_r[d]     = bv;
    e.res      = res;
    e.cyc      = cyc + 1 + lat;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(posedge clk);
    @(negedge clk);
    if (!hold) start_r[d] = 1'b0;
    if (tog) begin
      a_r[d] = ~av;
      b_r[d] = ~bv;
      sm_r[d] = ~sm;
    end
    repeat (lat + 1) @(negedge clk);
    start_r[d] = 1'b0;
  endtask

  task automatic cmp5(input string name, input logic [4:0] got, input logic [4:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %b required %b", name, got, req);
    end
  endtask

  typedef struct {
    int         d;
    bit         sm;
    logic [7:0] av;
    logic [7:0] bv;
    logic [2:0] res;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    bcount  = 0;
    rst_n   = 1'b0;
    start_r = '0;
    sm_r    = '0;
    for (int i = 0; i < 3; i++) begin a_r[i] = '0; b_r[i] = '0; end

    #2;
    for (int i = 0; i < 3; i++)
      cmp5($sformatf("reset_state_dut%0d", i),
           {busy_w[i], done_w[i], sm_w[i], eq_w[i], gt_w[i]}, 5'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //                d  sm  a      b      res lat
    vecs.push_back('{0, 0, 8'h80, 8'h7F, GT, 1});
    vecs.push_back('{0, 1, 8'h80, 8'h7F, LT, 1});
    vecs.push_back('{0, 1, 8'hFF, 8'hFE, GT, 8});
    vecs.push_back('{0, 0, 8'hA5, 8'hA5, EQ, 8});
    vecs.push_back('{0, 1, 8'hA5, 8'hA5, EQ, 8});
    vecs.push_back('{1, 1, 8'h80, 8'h7F, LT, 8});
    vecs.push_back('{2, 0, 8'h3C, 8'h3D, LT, 2});
    vecs.push_back('{2, 0, 8'hC3, 8'h3C, GT, 1});
    vecs.push_back('{2, 1, 8'h7F, 8'h80, GT, 1});
    foreach (vecs[i])
      issue(vecs[i].d, vecs[i].sm, vecs[i].av, vecs[i].bv, vecs[i].res, vecs[i].lat, 1'b0, 1'b0);

    // Previous equal result must hold until the new compare's done pulse.
    fork
      issue(0, 1'b0, 8'h00, 8'h01, LT, 8, 1'b0, 1'b0);
      begin
        repeat (5) @(negedge clk);
        cmp5("result_held_mid_compare", {busy_w[0], done_w[0], sm_w[0], eq_w[0], gt_w[0]}, 5'b10010);
      end
    join

    // Fixed latency: result after edge 8, busy exactly 8 cycles.
    bcount = 0;
    issue(1, 1'b0, 8'h80, 8'h00, GT, 8, 1'b0, 1'b0);
    @(posedge clk);
    checks++;
    if (bcount != 8) begin
      errors++;
      $display("FAIL busy_cycles got %0d required 8", bcount);
    end
    @(negedge clk);

    // start held through CMP and DONE: one done only (monitor flags extras).
    issue(0, 1'b0, 8'h80, 8'h7F, GT, 1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Operands and mode inverted mid-compare must not affect the result.
    issue(0, 1'b0, 8'h3C, 8'h3D, LT, 8, 1'b0, 1'b1);

    // Reset at edge 3 of an 8-cycle compare.
    start_r[0] = 1'b1;
    sm_r[0]    = 1'b0;
    a_r[0]     = 8'hA5;
    b_r[0]     = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    cmp5("mid_reset_outputs", {busy_w[0], done_w[0], sm_w[0], eq_w[0], gt_w[0]}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    cmp5("after_reset_idle", {busy_w[0], done_w[0], sm_w[0], eq_w[0], gt_w[0]}, 5'b0);
    issue(0, 1'b0, 8'h12, 8'h34, LT, 3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL missing_done dut0 got %0d pending required 0", q0.size()); end
    checks++;
    if (q1.size() != 0) begin errors++; $display("FAIL missing_done dut1 got %0d pending required 0", q1.size()); end
    checks++;
    if (q2.size() != 0) begin errors++; $display("FAIL missing_done dut2 got %0d pending required 0", q2.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
